// File: rtl/mem_loader.sv
// Boot loader: parses a length-prefixed byte stream into instruction and data
// memories, then releases the core (or flags an oversize length and halts).
module mem_loader #(
    parameter int IM_DEPTH = 256,
    parameter int DM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] im_addr,
    output logic [7:0]  im_wdata,
    output logic        im_wr,
    output logic [15:0] dm_addr,
    output logic [7:0]  dm_wdata,
    output logic        dm_wr,
    output logic        core_run,
    output logic        err
);

    typedef enum logic [3:0] {
        IDLE, IM_LH, IM_LL, IM_LOAD, DM_LH, DM_LL, DM_LOAD, RUN, ERROR
    } state_t;

    localparam logic [16:0] IM_MAX = 17'(IM_DEPTH);
    localparam logic [16:0] DM_MAX = 17'(DM_DEPTH);

    state_t      state_q;
    logic [15:0] imLen_q, dmLen_q, cnt_q;
    logic        rx_ready_q, im_wr_q, dm_wr_q, core_run_q, err_q;
    logic [15:0] im_addr_q, dm_addr_q;
    logic [7:0]  im_wdata_q, dm_wdata_q;

    logic        xfer;
    logic [15:0] imLenFull, dmLenFull, cntNext;

    assign xfer      = rx_valid & rx_ready_q;
    assign imLenFull = {imLen_q[15:8], rx_data};
    assign dmLenFull = {dmLen_q[15:8], rx_data};
    assign cntNext   = cnt_q + 16'd1;

    // cnt_q is shared by both payload phases and restarts at 0 for each.
    // core_run rises one cycle after the final DM strobe, i.e. the first
    // cycle spent in RUN drives it; a zero DM length sets it directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            imLen_q    <= '0;
            dmLen_q    <= '0;
            cnt_q      <= '0;
            rx_ready_q <= 1'b0;
            im_wr_q    <= 1'b0;
            dm_wr_q    <= 1'b0;
            core_run_q <= 1'b0;
            err_q      <= 1'b0;
            im_addr_q  <= '0;
            dm_addr_q  <= '0;
            im_wdata_q <= '0;
            dm_wdata_q <= '0;
        end else begin
            im_wr_q <= 1'b0;
            dm_wr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= IM_LH;
                        rx_ready_q <= 1'b1;
                    end
                end
                IM_LH: begin
                    if (xfer) begin
                        imLen_q[15:8] <= rx_data;
                        state_q       <= IM_LL;
                    end
                end
                IM_LL: begin
                    if (xfer) begin
                        imLen_q <= imLenFull;
                        cnt_q   <= '0;
                        if ({1'b0, imLenFull} > IM_MAX) begin
                            state_q    <= ERROR;
                            rx_ready_q <= 1'b0;
                            err_q      <= 1'b1;
                        end else if (imLenFull == 16'd0) begin
                            state_q <= DM_LH;
                        end else begin
                            state_q <= IM_LOAD;
                        end
                    end
                end
                IM_LOAD: begin
                    if (xfer) begin
                        im_wr_q    <= 1'b1;
                        im_addr_q  <= cnt_q;
                        im_wdata_q <= rx_data;
                        if (cntNext == imLen_q) begin
                            cnt_q   <= '0;
                            state_q <= DM_LH;
                        end else begin
                            cnt_q <= cntNext;
                        end
                    end
                end
                DM_LH: begin
                    if (xfer) begin
                        dmLen_q[15:8] <= rx_data;
                        state_q       <= DM_LL;
                    end
                end
                DM_LL: begin
                    if (xfer) begin
                        dmLen_q <= dmLenFull;
                        cnt_q   <= '0;
                        if ({1'b0, dmLenFull} > DM_MAX) begin
                            state_q    <= ERROR;
                            rx_ready_q <= 1'b0;
                            err_q      <= 1'b1;
                        end else if (dmLenFull == 16'd0) begin
                            state_q    <= RUN;
                            rx_ready_q <= 1'b0;
                            core_run_q <= 1'b1;
                        end else begin
                            state_q <= DM_LOAD;
                        end
                    end
                end
                DM_LOAD: begin
                    if (xfer) begin
                        dm_wr_q    <= 1'b1;
                        dm_addr_q  <= cnt_q;
                        dm_wdata_q <= rx_data;
                        if (cntNext == dmLen_q) begin
                            cnt_q      <= '0;
                            state_q    <= RUN;
                            rx_ready_q <= 1'b0;
                        end else begin
                            cnt_q <= cntNext;
                        end
                    end
                end
                RUN: begin
                    core_run_q <= 1'b1;
                end
                ERROR: begin
                    err_q <= 1'b1;
                end
                default: begin
                    state_q    <= IDLE;
                    rx_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready = rx_ready_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign im_wr    = im_wr_q;
    assign dm_addr  = dm_addr_q;
    assign dm_wdata = dm_wdata_q;
    assign dm_wr    = dm_wr_q;
    assign core_run = core_run_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Table-driven bench for mem_loader: per-cycle vectors with expected outputs,
// plus hand-written sequences for random gaps and mid-load reset.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [15:0] im_addr, dm_addr;
    logic [7:0]  im_wdata, dm_wdata;
    logic        im_wr, dm_wr, core_run, err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        st;
        logic        vld;
        logic [7:0]  data;
        logic        rdy;
        logic        run;
        logic        er;
        logic        imW;
        logic [15:0] imA;
        logic [7:0]  imD;
        logic        dmW;
        logic [15:0] dmA;
        logic [7:0]  dmD;
    } vec_t;

    vec_t vq[$];

    mem_loader #(.IM_DEPTH(256), .DM_DEPTH(1024)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .im_addr(im_addr), .im_wdata(im_wdata), .im_wr(im_wr),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wr(dm_wr),
        .core_run(core_run), .err(err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic st, logic vld, logic [7:0] d,
                                logic rdy, logic run, logic er,
                                logic imW, logic [15:0] imA, logic [7:0] imD,
                                logic dmW, logic [15:0] dmA, logic [7:0] dmD);
        vec_t v;
        v.rst = rst; v.st = st; v.vld = vld; v.data = d;
        v.rdy = rdy; v.run = run; v.er = er;
        v.imW = imW; v.imA = imA; v.imD = imD;
        v.dmW = dmW; v.dmA = dmA; v.dmD = dmD;
        return v;
    endfunction

    // Address/data only matter while their strobe is high, so they are masked otherwise.
    function automatic logic [52:0] observe();
        return {rx_ready, core_run, err,
                im_wr, im_wr ? im_addr : 16'h0, im_wr ? im_wdata : 8'h0,
                dm_wr, dm_wr ? dm_addr : 16'h0, dm_wr ? dm_wdata : 8'h0};
    endfunction

    function automatic logic [52:0] expOf(vec_t v);
        return {v.rdy, v.run, v.er, v.imW, v.imA, v.imD, v.dmW, v.dmA, v.dmD};
    endfunction

    function automatic logic [52:0] rawOut();
        return {rx_ready, im_addr, im_wdata, im_wr, dm_addr, dm_wdata, dm_wr, core_run, err};
    endfunction

    task automatic checkOutput(input string name, input logic [52:0] got, input logic [52:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.rst) begin
            rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0;
            #2;
            rst_n = 1'b1;
            #1;
        end
        start = v.st; rx_valid = v.vld; rx_data = v.data;
        @(posedge clk);
        #1;
        start = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic runVec(input string name, input vec_t v);
        applyStimulus(v);
        checkOutput(name, observe(), expOf(v));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] payload [16];
        int sent, wrCnt;
        logic v;

        // Session A: 3-byte IM, 2-byte DM, with a stall and a stray start mid-payload.
        vq.push_back(mk(1,1,0,8'h00, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        vq.push_back(mk(0,0,1,8'h00, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        vq.push_back(mk(0,0,1,8'h03, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        vq.push_back(mk(0,0,1,8'hA1, 1,0,0, 1,16'd0,8'hA1, 0,16'd0,8'h00));
        vq.push_back(mk(0,0,0,8'hFF, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        vq.push_back(mk(0,1,0,8'hFF, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        vq.push_back(mk(0,0,1,8'hA2, 1,0,0, 1,16'd1,8'hA2, 0,16'd0,8'h00));
        vq.push_back(mk(0,0,1,8'hA3, 1,0,0, 1,16'd2,8'hA3, 0,16'd0,8'h00));
        vq.push_back(mk(0,0,1,8'h00, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        vq.push_back(mk(0,0,1,8'h02, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        vq.push_back(mk(0,0,1,8'hB1, 1,0,0, 0,16'd0,8'h00, 1,16'd0,8'hB1));
        vq.push_back(mk(0,0,1,8'hB2, 0,0,0, 0,16'd0,8'h00, 1,16'd1,8'hB2));
        vq.push_back(mk(0,0,0,8'h00, 0,1,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        vq.push_back(mk(0,1,1,8'h77, 0,1,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        // Session B: empty IM, single DM byte.
        vq.push_back(mk(1,1,0,8'h00, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        vq.push_back(mk(0,0,1,8'h00, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        vq.push_back(mk(0,0,1,8'h00, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        vq.push_back(mk(0,0,1,8'h00, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        vq.push_back(mk(0,0,1,8'h01, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        vq.push_back(mk(0,0,1,8'hC7, 0,0,0, 0,16'd0,8'h00, 1,16'd0,8'hC7));
        vq.push_back(mk(0,0,0,8'h00, 0,1,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        // Session C: IM length 257 is oversize.
        vq.push_back(mk(1,1,0,8'h00, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        vq.push_back(mk(0,0,1,8'h01, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        vq.push_back(mk(0,0,1,8'h01, 0,0,1, 0,16'd0,8'h00, 0,16'd0,8'h00));
        vq.push_back(mk(0,0,1,8'h55, 0,0,1, 0,16'd0,8'h00, 0,16'd0,8'h00));
        vq.push_back(mk(0,1,0,8'h00, 0,0,1, 0,16'd0,8'h00, 0,16'd0,8'h00));
        // Session D: IM length exactly 256 is accepted.
        vq.push_back(mk(1,1,0,8'h00, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        vq.push_back(mk(0,0,1,8'h01, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        vq.push_back(mk(0,0,1,8'h00, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        // Session E: empty IM, DM length 1025 is oversize.
        vq.push_back(mk(1,1,0,8'h00, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        vq.push_back(mk(0,0,1,8'h00, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        vq.push_back(mk(0,0,1,8'h00, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        vq.push_back(mk(0,0,1,8'h04, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        vq.push_back(mk(0,0,1,8'h01, 0,0,1, 0,16'd0,8'h00, 0,16'd0,8'h00));

        #12;
        checkOutput("reset_state", rawOut(), 53'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vq[i]) runVec($sformatf("vec%0d", i), vq[i]);

        // Random rx_valid gaps across a 16-byte IM payload.
        for (int i = 0; i < 16; i++) payload[i] = 8'(8'h40 + 3 * i);
        runVec("rand_start", mk(1,1,0,8'h00, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        runVec("rand_lh",    mk(0,0,1,8'h00, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        runVec("rand_ll",    mk(0,0,1,8'h10, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        sent = 0;
        wrCnt = 0;
        for (int cyc = 0; cyc < 300 && sent < 16; cyc++) begin
            v = 1'($urandom_range(0, 1));
            applyStimulus(mk(0,0,v, v ? payload[sent] : 8'hEE, 0,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
            if (v) sent++;
            checkOutput("rand_strobe", {52'h0, im_wr}, {52'h0, v});
            if (im_wr && wrCnt < 16) begin
                checkOutput("rand_wr", {29'h0, im_addr, im_wdata}, {29'h0, 16'(wrCnt), payload[wrCnt]});
                wrCnt++;
            end
        end
        checkOutput("rand_count", 53'(wrCnt), 53'd16);
        checkOutput("rand_ready", {52'h0, rx_ready}, 53'h1);

        // Reset after the 2nd IM payload byte, then a fresh session.
        runVec("rst_start", mk(1,1,0,8'h00, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        runVec("rst_lh",    mk(0,0,1,8'h00, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        runVec("rst_ll",    mk(0,0,1,8'h10, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        runVec("rst_b0",    mk(0,0,1,8'h11, 1,0,0, 1,16'd0,8'h11, 0,16'd0,8'h00));
        runVec("rst_b1",    mk(0,0,1,8'h22, 1,0,0, 1,16'd1,8'h22, 0,16'd0,8'h00));
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", rawOut(), 53'h0);
        @(posedge clk);
        #1;
        checkOutput("reset_hold", rawOut(), 53'h0);
        rst_n = 1'b1;
        runVec("idle_wait", mk(0,0,1,8'h33, 0,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        runVec("new_start", mk(0,1,0,8'h00, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        runVec("new_lh",    mk(0,0,1,8'h00, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        runVec("new_ll",    mk(0,0,1,8'h01, 1,0,0, 0,16'd0,8'h00, 0,16'd0,8'h00));
        runVec("new_b0",    mk(0,0,1,8'h5A, 1,0,0, 1,16'd0,8'h5A, 0,16'd0,8'h00));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter IM_DEPTH, default 256: instruction-memory capacity in bytes.
REQ-002 Parameter DM_DEPTH, default 1024: data-memory capacity in bytes.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion and deassertion, active-low.
REQ-005 start  input  1  single-cycle pulse that begins a load session.
REQ-006 rx_data  input  8  incoming byte-stream data.
REQ-007 rx_valid  input  1  rx_data holds a valid byte.
REQ-008 rx_ready  output  1  loader can accept a byte this cycle.
REQ-009 im_addr  output  16  instruction-memory write address.
REQ-010 im_wdata  output  8  instruction-memory write data.
REQ-011 im_wr  output  1  instruction-memory write strobe.
REQ-012 dm_addr  output  16  data-memory write address.
REQ-013 dm_wdata  output  8  data-memory write data.
REQ-014 dm_wr  output  1  data-memory write strobe.
REQ-015 core_run  output  1  core is released from hold and may fetch.
REQ-016 err  output  1  a load session was aborted due to oversize length.

Function
REQ-017 Stream format: IM length high byte, IM length low byte, IM payload bytes, DM length high byte, DM length low byte, DM payload bytes.
REQ-018 FSM states: IDLE, IM_LH, IM_LL, IM_LOAD, DM_LH, DM_LL, DM_LOAD, RUN, ERROR.
REQ-019 A byte transfers only in a cycle with rx_valid=1 and rx_ready=1.
REQ-020 rx_ready is 1 in IM_LH, IM_LL, IM_LOAD, DM_LH, DM_LL and DM_LOAD, and 0 in all other states.
REQ-021 IDLE -> IM_LH on start=1; start is ignored in every other state.
REQ-022 IM_LH captures length[15:8] and moves to IM_LL on transfer.
REQ-023 IM_LL captures length[7:0] on transfer, then goes to ERROR if length>IM_DEPTH, to DM_LH if length=0, and to IM_LOAD otherwise.
REQ-024 IM_LOAD writes each transferred byte to the next sequential address starting at 0, and moves to DM_LH after exactly length bytes.
REQ-025 DM_LH, DM_LL and DM_LOAD mirror REQ-022 to REQ-024 against DM_DEPTH; a zero length goes to RUN, and completion goes to RUN.
REQ-026 Write latency: a payload byte transferred in cycle n produces im_wr/dm_wr=1 for exactly one cycle in n+1, with the registered address and data.
REQ-027 The address counter wraps in 16 bits; a wrap is unreachable because lengths are bounded by the depth check.
REQ-028 Back-to-back transfers (rx_valid held high) sustain one byte per cycle with no bubbles.
REQ-029 rx_valid=0 in the middle of a payload stalls the loader with no write, no address change and no timeout.
REQ-030 im_wr and dm_wr are never both 1 in the same cycle.
REQ-031 core_run=1 only in RUN, asserted in the cycle after the final DM write strobe (or after the DM_LL transfer if DM length=0).
REQ-032 RUN and ERROR are terminal; only rst_n exits them.
REQ-033 err=1 only in ERROR; in ERROR, core_run=0 and no further writes occur.
REQ-034 Header bytes never produce write strobes.

Reset
REQ-035 While rst_n=0: state=IDLE, rx_ready=0, im_wr=0, dm_wr=0, core_run=0, err=0, all addresses and data outputs =0, and both length registers =0.
REQ-036 Reset asserted in the middle of a load aborts immediately, including any pending write strobe, with no partial write issued after rst_n falls.
REQ-037 After rst_n rises, the loader waits in IDLE for a new start pulse.

Verification
REQ-038 Start, then stream 00 03 A1 A2 A3 00 02 B1 B2 -> im_wr at addresses 0..2 with A1..A3, dm_wr at addresses 0..1 with B1..B2, core_run=1 the cycle after the B2 strobe.
REQ-039 Stream 00 00 00 01 C7 -> no im_wr, one dm_wr at address 0 with C7, then core_run=1.
REQ-040 IM length 01 01 with IM_DEPTH=256 -> ERROR, err=1, rx_ready=0, no strobes, core_run stays 0.
REQ-041 Randomized rx_valid gaps across a 16-byte IM payload -> exactly 16 strobes at contiguous addresses 0..15 with matching data.
REQ-042 rst_n pulsed low after the 2nd IM payload byte -> all outputs 0 asynchronously; a fresh session then loads from address 0.
REQ-043 start pulsed during IM_LOAD and during RUN -> no state change.
